// File: rtl/sdram_cmd_sched_if.sv
// Host request channel of the SDRAM command scheduler: one read/write
// request per ready/valid handshake, address packed as {bank, row, col}.
interface sdram_cmd_sched_if #(
    parameter int unsigned ADDR_W = 22
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        output req_ready
    );
endinterface

// File: rtl/sdram_cmd_sched.sv
// Open-page SDRAM command scheduler. Tracks one open row per bank so page
// hits skip ACTIVATE, arbitrates auto-refresh ahead of host requests, and
// drives registered command pins plus write-enable and read-capture strobes.
// The FSM state always names the command on the pins in that cycle.
module sdram_cmd_sched #(
    parameter int unsigned BANK_W = 2,
    parameter int unsigned ROW_W  = 12,
    parameter int unsigned COL_W  = 8,
    parameter int unsigned ADD_W  = 12
) (
    input  logic              clk0,
    input  logic              reset,
    sdram_cmd_sched_if.slave  host,
    input  logic              ref_req,
    output logic              ref_ack,
    input  logic [2:0]        trcd,
    input  logic [2:0]        trp,
    input  logic [3:0]        trfc,
    input  logic [1:0]        cas_lat,
    input  logic [1:0]        bur_len,
    output logic [ADD_W-1:0]  sadd,
    output logic [BANK_W-1:0] ba,
    output logic              cs_n,
    output logic              ras_n,
    output logic              cas_n,
    output logic              we_n,
    output logic              cke,
    output logic              oe,
    output logic              rd_valid,
    output logic              cmack
);
    localparam int unsigned NBANK = 1 << BANK_W;
    // Longest read window ends at cas_lat 3 + 8 beats - 1.
    localparam int unsigned SR_W  = 11;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CmdNop = 4'b1111;
    localparam logic [3:0] CmdAct = 4'b0011;
    localparam logic [3:0] CmdRd  = 4'b0101;
    localparam logic [3:0] CmdWr  = 4'b0100;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdRef = 4'b0001;

    typedef enum logic [2:0] {
        StIdle, StPre, StAct, StWait, StRw, StBurst, StPreall, StRef
    } state_e;

    state_e             state_q, state_d, tgt_q, tgt_d, after;
    logic [3:0]         cnt_q, cnt_d, dly;
    logic               timed;
    logic               ready_q;
    logic [NBANK-1:0]   open_q;
    logic [ROW_W-1:0]   open_row_q [NBANK];
    logic               wr_q, wr_d;
    logic [BANK_W-1:0]  bank_q, bank_d, a_bank;
    logic [ROW_W-1:0]   row_q, row_d, a_row;
    logic [COL_W-1:0]   col_q, col_d, a_col;
    logic [SR_W-1:0]    rd_sr_q, rd_sr_d;
    logic [3:0]         cmd_d;
    logic [ADD_W-1:0]   sadd_d;
    logic [BANK_W-1:0]  ba_d;
    logic [3:0]         trcd_e, trp_e, trfc_e, beats;
    logic [1:0]         cl_e;

    // Zero timing codes behave as one cycle.
    assign trcd_e = (trcd == 3'd0) ? 4'd1 : {1'b0, trcd};
    assign trp_e  = (trp == 3'd0) ? 4'd1 : {1'b0, trp};
    assign trfc_e = (trfc == 4'd0) ? 4'd1 : trfc;
    assign cl_e   = (cas_lat == 2'd0) ? 2'd1 : cas_lat;
    assign beats  = 4'd1 << bur_len;

    assign {a_bank, a_row, a_col} = host.req_addr;
    // ready_q is only set when the registered state is IDLE outside reset.
    assign host.req_ready = ready_q & ~ref_req;
    assign rd_valid       = rd_sr_q[0];

    // Next-state: request/refresh arbitration, delay counting, burst hold.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        dly     = 4'd1;
        after   = StIdle;
        timed   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ready_q && ref_req) begin
                    state_d = (|open_q) ? StPreall : StRef;
                end else if (ready_q && host.req_valid) begin
                    wr_d   = host.req_write;
                    bank_d = a_bank;
                    row_d  = a_row;
                    col_d  = a_col;
                    if (!open_q[a_bank]) begin
                        state_d = StAct;
                    end else if (open_row_q[a_bank] == a_row) begin
                        state_d = StRw;
                    end else begin
                        state_d = StPre;
                    end
                end
            end
            StPre: begin
                timed = 1'b1;
                dly   = trp_e;
                after = StAct;
            end
            StAct: begin
                timed = 1'b1;
                dly   = trcd_e;
                after = StRw;
            end
            StPreall: begin
                timed = 1'b1;
                dly   = trp_e;
                after = StRef;
            end
            StRef: begin
                timed = 1'b1;
                dly   = trfc_e;
                after = StIdle;
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = tgt_q;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StRw: begin
                if (beats == 4'd1) begin
                    state_d = StIdle;
                end else begin
                    state_d = StBurst;
                    cnt_d   = beats - 4'd2;
                end
            end
            StBurst: begin
                if (cnt_q == 4'd0) state_d = StIdle;
                else               cnt_d   = cnt_q - 4'd1;
            end
        endcase
        // The issuing cycle counts as the first of the delay.
        if (timed) begin
            if (dly == 4'd1) begin
                state_d = after;
            end else begin
                state_d = StWait;
                tgt_d   = after;
                cnt_d   = dly - 4'd2;
            end
        end
    end

    // Pin decode for the state being entered, so the pins are registered.
    always_comb begin
        cmd_d  = CmdNop;
        sadd_d = '0;
        ba_d   = '0;
        case (state_d)
            StAct: begin
                cmd_d  = CmdAct;
                sadd_d = ADD_W'(row_d);
                ba_d   = bank_d;
            end
            StRw: begin
                cmd_d      = wr_d ? CmdWr : CmdRd;
                sadd_d     = ADD_W'(col_d);
                sadd_d[10] = 1'b0;
                ba_d       = bank_d;
            end
            StPre: begin
                cmd_d = CmdPre;
                ba_d  = bank_d;
            end
            StPreall: begin
                cmd_d      = CmdPre;
                sadd_d[10] = 1'b1;
            end
            StRef:   cmd_d = CmdRef;
            default: ;
        endcase
    end

    // Read-capture window: B ones placed cas_lat slots ahead, shifted out.
    always_comb begin
        rd_sr_d = rd_sr_q >> 1;
        if (state_d == StRw && !wr_d) begin
            rd_sr_d = rd_sr_d | (((SR_W'(1) << beats) - SR_W'(1)) << cl_e);
        end
    end

    // State, bank tracking and registered outputs with synchronous reset.
    always_ff @(posedge clk0) begin
        if (!reset) begin
            state_q <= StIdle;
            tgt_q   <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            open_q  <= '0;
            wr_q    <= 1'b0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rd_sr_q <= '0;
            sadd    <= '0;
            ba      <= '0;
            {cs_n, ras_n, cas_n, we_n} <= CmdNop;
            cke     <= 1'b0;
            oe      <= 1'b0;
            ref_ack <= 1'b0;
            cmack   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == StIdle);
            wr_q    <= wr_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rd_sr_q <= rd_sr_d;
            sadd    <= sadd_d;
            ba      <= ba_d;
            {cs_n, ras_n, cas_n, we_n} <= cmd_d;
            cke     <= 1'b1;
            oe      <= wr_d && (state_d == StRw || state_d == StBurst);
            ref_ack <= (state_d == StRef);
            cmack   <= (state_d == StRw);
            if (state_d == StAct)      open_q[bank_d] <= 1'b1;
            else if (state_d == StPre) open_q[bank_d] <= 1'b0;
            else if (state_d == StRef) open_q         <= '0;
        end
    end

    // Open-row storage; only meaningful while the bank's open flag is set.
    always_ff @(posedge clk0) begin
        if (state_d == StAct) open_row_q[bank_d] <= row_d;
    end
endmodule

// File: doc/sdram_cmd_sched.md
# sdram_cmd_sched

Parametrised open-page SDRAM command scheduler, the next-generation replacement for the fixed-geometry SDRAM controller FSM. It accepts one read/write request at a time through a ready/valid handshake and tracks an open row per bank, so page hits skip ACTIVATE. It arbitrates auto-refresh against requests and drives the SDRAM command pins plus write-data-enable and read-capture strobes. It sits between the host command interface and the SDRAM pads.

## Interface
- BANK_W, 2: bank address bits; NBANK = 2^BANK_W.
- ROW_W, 12: row address bits.
- COL_W, 8: column address bits.
- ADD_W, 12: SDRAM address pin width; must be >= max(ROW_W, COL_W) and >= 11.
- clk0  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  scheduler accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  BANK_W+ROW_W+COL_W  {bank, row, col}.
- ref_req  in  1  refresh request level, held until ref_ack.
- ref_ack  out  1  one-cycle pulse coincident with the REFRESH command.
- trcd  in  3  ACT to READ/WRITE delay in cycles; 0 is treated as 1.
- trp  in  3  PRE to next command delay; 0 is treated as 1.
- trfc  in  4  REFRESH to next command delay; 0 is treated as 1.
- cas_lat  in  2  read latency 1..3; 0 is treated as 1.
- bur_len  in  2  burst length code; 0/1/2/3 mean 1/2/4/8 beats.
- sadd  out  ADD_W  SDRAM address.
- ba  out  BANK_W  SDRAM bank.
- cs_n, ras_n, cas_n, we_n  out  1 each  SDRAM command pins.
- cke  out  1  clock enable.
- oe  out  1  write-data drive enable.
- rd_valid  out  1  read data capture strobe.
- cmack  out  1  one-cycle pulse when a request's READ/WRITE command issues.

## Operation
- Commands as {ras_n, cas_n, we_n}, with cs_n=0 except for NOP:
  - NOP: cs_n=1, 111.
  - ACT: 011, sadd = row.
  - READ: 101, sadd = col, A10=0.
  - WRITE: 100, sadd = col, A10=0.
  - PRE: 010, A10=0, ba = bank.
  - PREALL: 010, A10=1.
  - REF: 001.
- Unused sadd bits are 0.
- Per-bank state: open flag plus ROW_W open-row register.
- FSM states: IDLE, PRE, ACT, WAIT (generic down-counter), RW, BURST, PREALL, REF.
- IDLE with ref_req=1 has priority over req_valid:
  - Any bank open: PREALL, wait trp, then REF.
  - No bank open: REF directly.
  - After REF, wait trfc, return to IDLE. All open flags clear at REF.
- IDLE with a request accepted:
  - Page hit (bank open, row equal): RW.
  - Bank closed: ACT, wait trcd, RW.
  - Row conflict: PRE, wait trp, ACT, wait trcd, RW.
  - ACT sets the bank's open flag and row register; PRE clears the flag.
- The request (write flag, bank, row, col) is latched at acceptance.
- RW issues READ or WRITE, pulses cmack, then holds BURST for B−1 cycles (B = beats) before IDLE.
- Write: oe=1 for B cycles starting the cycle WRITE is on the pins.
- Read: rd_valid=1 for B cycles starting cas_lat cycles after READ. This runs from an independent shift register, so it may overlap later commands.
- req_ready=1 only in IDLE with ref_req=0.
- trcd/trp/trfc/cas_lat/bur_len are sampled at use and must be stable while not IDLE.

## Timing
- Outputs are registered.
- A request accepted at edge N puts its first command on the pins in cycle N+1.
  - Hit: READ/WRITE at N+1.
  - Closed: ACT at N+1, READ/WRITE at N+1+trcd.
  - Conflict: PRE at N+1, ACT at N+1+trp, READ/WRITE at N+1+trp+trcd.
- Next request can be accepted B cycles after READ/WRITE issue.
- ref_req seen in IDLE at edge N: REF at N+1 (no open bank) or PREALL at N+1 and REF at N+1+trp. req_ready returns trfc cycles after REF.
- All non-command cycles drive NOP.
- Reset (reset=0 at an edge), including mid-burst or mid-wait:
  - State IDLE; all open flags, counters and the rd_valid shift register clear.
  - Outputs: sadd=0, ba=0, cs_n=ras_n=cas_n=we_n=1, cke=0, oe=0, rd_valid=0, ref_ack=0, cmack=0, req_ready=0.
- First cycle after reset release: cke=1, req_ready=1 if ref_req=0.

## Test plan
- Reset, then read bank 1 row 0x05 col 0x10 with trcd=2, cas_lat=2, B=4 -> ACT ba=1 sadd=0x005 at N+1; READ sadd=0x010 and cmack at N+3; rd_valid at N+5..N+8.
- Repeat a read to bank 1 row 0x05 -> READ at N+1, no ACT.
- Write to bank 1 row 0x06 with trp=3 -> PRE at N+1; ACT at N+4; WRITE at N+6; oe high 4 cycles from N+6.
- ref_req and req_valid asserted together with bank 1 open -> PREALL with sadd[10]=1; REF plus ref_ack trp later; req_ready low until trfc after REF; a following access to bank 1 issues ACT.
- bur_len=0 versus 3 -> oe/rd_valid width of 1 versus 8; req_ready re-asserts accordingly.
- reset=0 during BURST -> all outputs take reset values the next cycle; rd_valid drops; subsequent access to a previously open bank issues ACT.
